// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct constants, forwarding encodings and hazard FSM states
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_EX = 2'b01, FWD_WB = 2'b10} fwd_e;
  typedef enum logic [1:0] {IDLE, LD_STALL, MD_WAIT} state_e;
  // Only R-type, branches comparing two registers and stores actually read rt
  function automatic logic reads_rt(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
  endfunction
  // HI/LO readers and new mult/div ops must wait for the unit to drain
  function automatic logic is_md_dep(input logic [5:0] op, input logic [5:0] fn);
    return op == OP_RTYPE && (fn inside {FN_MFHI, FN_MFLO} || fn inside {[FN_MULT:FN_DIVU]});
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_md_timer.sv
// md_timer: mult/div occupancy timer, loaded on issue and counted down to idle
module md_timer #(
  parameter int LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);
  logic [5:0] cnt;
  // Load ignored while busy; busy drops the cycle after the count reaches zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 6'd0;
      busy <= 1'b0;
    end else if (load && !busy) begin
      cnt  <= 6'(LAT - 1);
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == 6'd0) busy <= 1'b0;
      else cnt <= cnt - 6'd1;
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: operand forwarding, load-use and mult/div stalls, branch flush
module pipe_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MD_LAT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_ins,
  input  logic [4:0]  ex_wr_reg,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  wb_wr_reg,
  input  logic        wb_reg_write,
  input  logic        md_issue,
  input  logic        branch_taken,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        stall,
  output logic        flush_id,
  output logic        md_busy,
  output logic [15:0] stall_cnt
);
  state_e state, state_nx;
  logic [4:0] rs, rt;
  logic [5:0] op, fn;
  logic use_rt, ex_ok, wb_ok, load_use, md_stall;
  logic unused_bits;
  assign op = id_ins[31:26];
  assign rs = id_ins[25:21];
  assign rt = id_ins[20:16];
  assign fn = id_ins[5:0];
  assign unused_bits = ^id_ins[15:6];
  md_timer #(.LAT(MD_LAT)) u_md (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (md_issue),
    .busy  (md_busy)
  );
  // Hazard detection, forwarding muxes and next state; LD_STALL masks the held load so the bubble is one cycle
  always_comb begin
    use_rt   = reads_rt(op);
    ex_ok    = ex_reg_write && ex_wr_reg != 5'd0;
    wb_ok    = wb_reg_write && wb_wr_reg != 5'd0;
    load_use = state != LD_STALL && ex_mem_read && ex_ok && (ex_wr_reg == rs || (use_rt && ex_wr_reg == rt));
    md_stall = md_busy && is_md_dep(op, fn);
    flush_id = rst_n && branch_taken;
    stall    = rst_n && !branch_taken && (md_stall || load_use);
    fwd_a    = !rst_n ? FWD_RF : (ex_ok && !ex_mem_read && ex_wr_reg == rs) ? FWD_EX :
               (wb_ok && wb_wr_reg == rs) ? FWD_WB : FWD_RF;
    fwd_b    = (!rst_n || !use_rt) ? FWD_RF : (ex_ok && !ex_mem_read && ex_wr_reg == rt) ? FWD_EX :
               (wb_ok && wb_wr_reg == rt) ? FWD_WB : FWD_RF;
    state_nx = branch_taken ? IDLE : md_stall ? MD_WAIT : (state == MD_WAIT && md_busy) ? MD_WAIT :
               (state == IDLE && load_use) ? LD_STALL : IDLE;
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= 16'd0;
    else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MD_LAT, default 32, meaning mult/div latency in cycles; legal range 2..63.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 id_ins  in  32  instruction in decode; rs=[25:21], rt=[20:16], opcode=[31:26], funct=[5:0].
REQ-005 ex_wr_reg  in  5  destination register of instruction in EX.
REQ-006 ex_reg_write  in  1  EX instruction writes the register file.
REQ-007 ex_mem_read  in  1  EX instruction is a load.
REQ-008 wb_wr_reg  in  5  destination register of instruction in WB.
REQ-009 wb_reg_write  in  1  WB instruction writes the register file.
REQ-010 md_issue  in  1  ID instruction is MULT/MULTU/DIV/DIVU and is leaving ID this cycle.
REQ-011 branch_taken  in  1  taken branch/jump resolved this cycle.
REQ-012 fwd_a  out  2  rs operand source: 00 regfile, 01 EX result, 10 WB result.
REQ-013 fwd_b  out  2  rt operand source, same encoding.
REQ-014 stall  out  1  hold PC and IF/ID register.
REQ-015 flush_id  out  1  convert IF/ID contents to bubble.
REQ-016 md_busy  out  1  mult/div unit occupied.
REQ-017 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-018 Forward rs: 01 if ex_reg_write, ex_wr_reg!=0, ex_wr_reg==rs, ex_mem_read=0; else 10 if wb_reg_write, wb_wr_reg!=0, wb_wr_reg==rs; else 00; EX match takes priority over WB.
REQ-019 fwd_b identical using rt, evaluated only when ID reads rt (opcode 0, 0x04, 0x05, 0x2B); otherwise 00.
REQ-020 Load-use hazard: ex_mem_read & ex_reg_write & ex_wr_reg!=0 & ex_wr_reg matches rs or used rt -> stall=1 same cycle (combinational), FSM IDLE->LD_STALL.
REQ-021 LD_STALL lasts exactly one cycle, then IDLE; during it forwarding evaluates normally (load now in WB yields 10).
REQ-022 md_issue while md_busy=0 loads md timer with MD_LAT-1 and sets md_busy next cycle; md_busy clears the cycle after timer reaches 0.
REQ-023 While md_busy=1, stall=1 if ID holds MFHI (funct 0x10), MFLO (0x12), or another MULT/DIV (funct 0x18..0x1B); md_issue asserted while md_busy=1 is ignored.
REQ-024 branch_taken -> flush_id=1 same cycle, FSM to IDLE next cycle; pending LD_STALL is cancelled; md timer continues.
REQ-025 Priority: flush_id > mult/div stall > load-use stall; stall=0 whenever flush_id=1.
REQ-026 FSM states IDLE, LD_STALL, MD_WAIT; MD_WAIT entered when mult/div stall asserted, exits to IDLE when md_busy falls.
REQ-027 stall_cnt increments each cycle stall=1, saturates at 0xFFFF, never wraps.
REQ-028 All outputs free of X after reset; combinational outputs derived only from registered state and current inputs.

Reset
REQ-029 rst_n low asynchronously forces FSM=IDLE, md timer=0, md_busy=0, stall_cnt=0.
REQ-030 During reset fwd_a=fwd_b=00, stall=0, flush_id=0; reset mid mult/div abandons the operation.

Structure
REQ-031 Opcode/funct constants, forwarding encodings and FSM state enumeration belong in shared package mips_pkg.
REQ-032 One sub-module md_timer (load, count-down, busy) instantiated once; everything else inline.

Verification
REQ-033 EX writes $8 (no load), ID add rs=$8 rt=$9, WB writes $9 -> fwd_a=01, fwd_b=10, stall=0.
REQ-034 EX lw $8, ID add rs=$8 -> stall=1 one cycle, next cycle fwd_a=10, stall=0, stall_cnt=1.
REQ-035 ex_wr_reg=0 with ex_reg_write=1, ID rs=$0 -> fwd_a=00, no stall.
REQ-036 md_issue with MD_LAT=32, then ID MFLO -> stall=1 for cycles until md_busy falls at cycle 32, stall_cnt matches.
REQ-037 Load-use hazard and branch_taken same cycle -> flush_id=1, stall=0, next cycle FSM IDLE.
REQ-038 rst_n low mid mult/div -> md_busy=0, stall_cnt=0 immediately, no stall after release.
